// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : Hazard and forwarding control for an in-order pipeline.
//               Tracks the {valid, rd, reg_write, mem_read} state of the
//               post-ID stages (entry 0 = EX ... entry DEPTH-1 = WB).
//               Using that state it selects forwarding sources for the ID
//               operands, detects load-use hazards, handles EX redirects and
//               freezes the pipeline while data memory is busy. It also keeps
//               saturating stall/flush performance counters.
// Ports       : clk, rst (async, active-high)
//               i_id_*        : ID-stage instruction description
//               i_ex_redirect : taken branch / jump in EX
//               i_mem_busy    : data memory not ready (freeze)
//               o_stall_if/id, o_flush_if/id, o_freeze : pipeline control
//               o_fwd_rs1/2   : 0 = regfile, k+1 = result of stage k
//               o_stage_valid : valid bit per tracked stage
//               o_stall_cnt, o_flush_cnt : saturating event counters
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
  parameter int AW         = 5,
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 2,
  parameter int CW         = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_id_valid,
  input  logic [AW-1:0]                i_id_rs1,
  input  logic [AW-1:0]                i_id_rs2,
  input  logic                         i_id_rs1_used,
  input  logic                         i_id_rs2_used,
  input  logic [AW-1:0]                i_id_rd,
  input  logic                         i_id_reg_write,
  input  logic                         i_id_mem_read,
  input  logic                         i_ex_redirect,
  input  logic                         i_mem_busy,
  output logic                         o_stall_if,
  output logic                         o_stall_id,
  output logic                         o_freeze,
  output logic                         o_flush_if,
  output logic                         o_flush_id,
  output logic [$clog2(DEPTH+1)-1:0]   o_fwd_rs1,
  output logic [$clog2(DEPTH+1)-1:0]   o_fwd_rs2,
  output logic [DEPTH-1:0]             o_stage_valid,
  output logic [CW-1:0]                o_stall_cnt,
  output logic [CW-1:0]                o_flush_cnt
);

  localparam int c_fw = $clog2(DEPTH+1);

  // Stage tracking shift register, bit/element k describes stage k
  logic [DEPTH-1:0] r_valid;
  logic [DEPTH-1:0] r_reg_write;
  logic [DEPTH-1:0] r_mem_read;
  logic [AW-1:0]    r_rd [DEPTH];
  logic [CW-1:0]    r_stall_cnt;
  logic [CW-1:0]    r_flush_cnt;

  logic [c_fw-1:0]  w_fwd_rs1;
  logic [c_fw-1:0]  w_fwd_rs2;
  logic             w_lu_rs1;
  logic             w_lu_rs2;
  logic             w_load_use;
  logic             w_stall;
  logic             w_flush_if;
  logic             w_flush_id;
  logic             w_bubble;

  // Scan from oldest to youngest so the youngest match overwrites older ones.
  always_comb begin
    w_fwd_rs1 = '0;
    w_fwd_rs2 = '0;
    w_lu_rs1  = 1'b0;
    w_lu_rs2  = 1'b0;
    for (int k = DEPTH-1; k >= 0; k--) begin
      if (r_valid[k] && r_reg_write[k] && i_id_rs1_used &&
          (i_id_rs1 != '0) && (r_rd[k] == i_id_rs1)) begin
        w_fwd_rs1 = c_fw'(k+1);
        w_lu_rs1  = r_mem_read[k] && (k < LOAD_STAGE);
      end
      if (r_valid[k] && r_reg_write[k] && i_id_rs2_used &&
          (i_id_rs2 != '0) && (r_rd[k] == i_id_rs2)) begin
        w_fwd_rs2 = c_fw'(k+1);
        w_lu_rs2  = r_mem_read[k] && (k < LOAD_STAGE);
      end
    end
  end

  // A bubble in ID never needs operands, so it never causes a load-use stall.
  assign w_load_use = i_id_valid && (w_lu_rs1 || w_lu_rs2);

  // Priority: freeze > redirect > load-use. While frozen, redirect and
  // load-use are simply re-evaluated once memory releases the pipeline.
  always_comb begin
    w_stall    = 1'b0;
    w_flush_if = 1'b0;
    w_flush_id = 1'b0;
    if (i_mem_busy) begin
      w_stall = 1'b1;
    end else if (i_ex_redirect) begin
      w_flush_if = 1'b1;
      w_flush_id = 1'b1;
    end else if (w_load_use) begin
      w_stall    = 1'b1;
      w_flush_id = 1'b1;
    end
    if (rst) begin
      w_stall    = 1'b0;
      w_flush_if = 1'b0;
      w_flush_id = 1'b0;
    end
  end

  assign w_bubble = i_ex_redirect || w_load_use;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid     <= '0;
      r_reg_write <= '0;
      r_mem_read  <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        r_rd[k] <= '0;
      end
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!i_mem_busy) begin
        r_valid     <= {r_valid[DEPTH-2:0],     i_id_valid     && !w_bubble};
        r_reg_write <= {r_reg_write[DEPTH-2:0], i_id_reg_write && !w_bubble};
        r_mem_read  <= {r_mem_read[DEPTH-2:0],  i_id_mem_read  && !w_bubble};
        for (int k = DEPTH-1; k > 0; k--) begin
          r_rd[k] <= r_rd[k-1];
        end
        r_rd[0] <= w_bubble ? '0 : i_id_rd;
      end
      if (w_stall && (r_stall_cnt != {CW{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + CW'(1);
      end
      if (w_flush_if && (r_flush_cnt != {CW{1'b1}})) begin
        r_flush_cnt <= r_flush_cnt + CW'(1);
      end
    end
  end

  assign o_stall_if    = w_stall;
  assign o_stall_id    = w_stall;
  assign o_freeze      = i_mem_busy && !rst;
  assign o_flush_if    = w_flush_if;
  assign o_flush_id    = w_flush_id;
  assign o_fwd_rs1     = w_fwd_rs1;
  assign o_fwd_rs2     = w_fwd_rs2;
  assign o_stage_valid = r_valid;
  assign o_stall_cnt   = r_stall_cnt;
  assign o_flush_cnt   = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_hazard_ctrl
// Description : Self-checking bench for pipe_hazard_ctrl. Directed scenarios
//               plus a randomized run against a queue-based pipeline model.
//               Counters are narrowed to 4 bits so saturation is reachable.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

  localparam int AW = 5;
  localparam int DEPTH = 3;
  localparam int LOAD_STAGE = 2;
  localparam int CW = 4;
  localparam int CMAX = 15;

  logic clk, rst;
  logic id_valid, id_rs1_used, id_rs2_used, id_reg_write, id_mem_read;
  logic [AW-1:0] id_rs1, id_rs2, id_rd;
  logic ex_redirect, mem_busy;
  logic o_stall_if, o_stall_id, o_freeze, o_flush_if, o_flush_id;
  logic [1:0] o_fwd_rs1, o_fwd_rs2;
  logic [DEPTH-1:0] o_stage_valid;
  logic [CW-1:0] o_stall_cnt, o_flush_cnt;

  int n_cmp = 0;
  int n_fail = 0;

  pipe_hazard_ctrl #(.AW(AW), .DEPTH(DEPTH), .LOAD_STAGE(LOAD_STAGE), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .i_id_valid(id_valid), .i_id_rs1(id_rs1), .i_id_rs2(id_rs2),
    .i_id_rs1_used(id_rs1_used), .i_id_rs2_used(id_rs2_used),
    .i_id_rd(id_rd), .i_id_reg_write(id_reg_write), .i_id_mem_read(id_mem_read),
    .i_ex_redirect(ex_redirect), .i_mem_busy(mem_busy),
    .o_stall_if(o_stall_if), .o_stall_id(o_stall_id), .o_freeze(o_freeze),
    .o_flush_if(o_flush_if), .o_flush_id(o_flush_id),
    .o_fwd_rs1(o_fwd_rs1), .o_fwd_rs2(o_fwd_rs2),
    .o_stage_valid(o_stage_valid), .o_stall_cnt(o_stall_cnt), .o_flush_cnt(o_flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {bit v; int rd; bit rw; bit mr;} ent_t;
  localparam ent_t BUB = '{v: 1'b0, rd: 0, rw: 1'b0, mr: 1'b0};
  ent_t m_pipe[$];          // front = youngest (EX), back = oldest (WB)
  int   m_stall, m_flush;
  bit   e_stall, e_flush_if, e_flush_id, e_lu;
  int   e_fwd1, e_fwd2;

  function automatic void model_reset();
    m_pipe = '{BUB, BUB, BUB};
    m_stall = 0;
    m_flush = 0;
  endfunction

  // Youngest in-flight writer of rs decides both the forward source and
  // whether its data is still too early (a load not yet at LOAD_STAGE).
  function automatic void m_lookup(input int rs, input bit used, output int fwd, output bit lu);
    fwd = 0;
    lu = 1'b0;
    if (used && rs != 0) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (m_pipe[k].v && m_pipe[k].rw && m_pipe[k].rd == rs) begin
          fwd = k + 1;
          lu = m_pipe[k].mr && (k < LOAD_STAGE);
          break;
        end
      end
    end
  endfunction

  function automatic void model_eval();
    bit l1, l2;
    m_lookup(int'(id_rs1), id_rs1_used, e_fwd1, l1);
    m_lookup(int'(id_rs2), id_rs2_used, e_fwd2, l2);
    e_lu = id_valid && (l1 || l2);
    e_stall = mem_busy || (!ex_redirect && e_lu);
    e_flush_if = !mem_busy && ex_redirect;
    e_flush_id = !mem_busy && (ex_redirect || e_lu);
  endfunction

  function automatic void model_advance();
    ent_t n;
    if (!mem_busy) begin
      if (ex_redirect || e_lu) n = BUB;
      else n = '{v: id_valid, rd: int'(id_rd), rw: id_reg_write, mr: id_mem_read};
      m_pipe.push_front(n);
      void'(m_pipe.pop_back());
    end
    if (e_stall && m_stall < CMAX) m_stall++;
    if (e_flush_if && m_flush < CMAX) m_flush++;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic drive(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                       input int rd, input bit rw, input bit mr, input bit redir, input bit mb);
    id_valid = v; id_rs1 = AW'(rs1); id_rs1_used = u1; id_rs2 = AW'(rs2); id_rs2_used = u2;
    id_rd = AW'(rd); id_reg_write = rw; id_mem_read = mr; ex_redirect = redir; mem_busy = mb;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    model_eval();
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    drive(1, 5, 1, 6, 1, 5, 1, 1, 1, 0);
    #2;
    n_cmp++; if (o_stage_valid !== 3'b000) begin n_fail++; $display("FAIL reset_stage_valid: got %b want 000", o_stage_valid); end
    n_cmp++; if (o_stall_cnt !== 4'd0 || o_flush_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_counters: got %0d/%0d want 0/0", o_stall_cnt, o_flush_cnt); end
    n_cmp++; if ({o_stall_if, o_stall_id, o_flush_if, o_flush_id} !== 4'b0000) begin n_fail++; $display("FAIL reset_ctrl: got %b want 0000", {o_stall_if, o_stall_id, o_flush_if, o_flush_id}); end
    n_cmp++; if (o_fwd_rs1 !== 2'd0 || o_fwd_rs2 !== 2'd0) begin n_fail++; $display("FAIL reset_fwd: got %0d/%0d want 0/0", o_fwd_rs1, o_fwd_rs2); end
    do_reset();
  endtask

  task automatic test_forward_ex();
    do_reset();
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);       // add x5
    tick();
    drive(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);       // reads x5
    @(negedge clk);
    n_cmp++; if (o_fwd_rs1 !== 2'd1) begin n_fail++; $display("FAIL fwd_ex_rs1: got %0d want 1", o_fwd_rs1); end
    n_cmp++; if (o_stall_id !== 1'b0) begin n_fail++; $display("FAIL fwd_ex_nostall: got %b want 0", o_stall_id); end
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    drive(1, 0, 0, 0, 0, 6, 1, 1, 0, 0);       // lw x6
    tick();
    drive(1, 0, 0, 6, 1, 9, 1, 0, 0, 0);       // reads x6 as rs2
    @(negedge clk);
    n_cmp++; if ({o_stall_if, o_stall_id, o_flush_if, o_flush_id} !== 4'b1101) begin n_fail++; $display("FAIL lu_first_ctrl: got %b want 1101", {o_stall_if, o_stall_id, o_flush_if, o_flush_id}); end
    tick();
    @(negedge clk);
    n_cmp++; if (o_stall_id !== 1'b1 || o_fwd_rs2 !== 2'd2) begin n_fail++; $display("FAIL lu_second: got stall=%b fwd=%0d want stall=1 fwd=2", o_stall_id, o_fwd_rs2); end
    tick();
    @(negedge clk);
    n_cmp++; if (o_stall_id !== 1'b0 || o_fwd_rs2 !== 2'd3) begin n_fail++; $display("FAIL lu_release: got stall=%b fwd=%0d want stall=0 fwd=3", o_stall_id, o_fwd_rs2); end
    n_cmp++; if (o_stall_cnt !== 4'd2) begin n_fail++; $display("FAIL lu_stall_cnt: got %0d want 2", o_stall_cnt); end
    tick();
  endtask

  task automatic test_youngest();
    do_reset();
    drive(1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
    tick();
    drive(1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
    tick();
    drive(1, 7, 1, 7, 1, 0, 0, 0, 0, 0);
    @(negedge clk);
    n_cmp++; if (o_fwd_rs1 !== 2'd1 || o_fwd_rs2 !== 2'd1) begin n_fail++; $display("FAIL youngest_fwd: got %0d/%0d want 1/1", o_fwd_rs1, o_fwd_rs2); end
    do_reset();
    drive(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);       // writes x0
    tick();
    drive(1, 0, 1, 0, 1, 0, 0, 0, 0, 0);
    @(negedge clk);
    n_cmp++; if (o_fwd_rs1 !== 2'd0 || o_fwd_rs2 !== 2'd0) begin n_fail++; $display("FAIL x0_fwd: got %0d/%0d want 0/0", o_fwd_rs1, o_fwd_rs2); end
    tick();
  endtask

  task automatic test_redirect_over_loaduse();
    do_reset();
    drive(1, 0, 0, 0, 0, 6, 1, 1, 0, 0);
    tick();
    drive(1, 0, 0, 6, 1, 9, 1, 0, 1, 0);       // load-use plus redirect
    @(negedge clk);
    n_cmp++; if ({o_stall_if, o_stall_id, o_flush_if, o_flush_id} !== 4'b0011) begin n_fail++; $display("FAIL redir_ctrl: got %b want 0011", {o_stall_if, o_stall_id, o_flush_if, o_flush_id}); end
    tick();
    idle();
    n_cmp++; if (o_flush_cnt !== 4'd1 || o_stall_cnt !== 4'd0) begin n_fail++; $display("FAIL redir_cnt: got flush=%0d stall=%0d want 1/0", o_flush_cnt, o_stall_cnt); end
    n_cmp++; if (o_stage_valid !== 3'b010) begin n_fail++; $display("FAIL redir_bubble: got %b want 010", o_stage_valid); end
  endtask

  task automatic test_freeze();
    do_reset();
    drive(1, 0, 0, 0, 0, 6, 1, 1, 0, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 6, 1, 9, 1, 0, 1, 1);     // redirect too, must be ignored
      @(negedge clk);
      n_cmp++; if ({o_freeze, o_stall_id, o_flush_if, o_flush_id} !== 4'b1100 || o_stage_valid !== 3'b001) begin
        n_fail++; $display("FAIL freeze_cycle%0d: got ctrl=%b sv=%b want 1100 001", i, {o_freeze, o_stall_id, o_flush_if, o_flush_id}, o_stage_valid); end
      tick();
    end
    drive(1, 0, 0, 6, 1, 9, 1, 0, 0, 0);
    @(negedge clk);
    n_cmp++; if (o_stall_cnt !== 4'd3) begin n_fail++; $display("FAIL freeze_stall_cnt: got %0d want 3", o_stall_cnt); end
    n_cmp++; if ({o_freeze, o_stall_id, o_flush_id} !== 3'b011) begin n_fail++; $display("FAIL freeze_release: got %b want 011", {o_freeze, o_stall_id, o_flush_id}); end
    tick();
    n_cmp++; if (o_stall_cnt !== 4'd4) begin n_fail++; $display("FAIL freeze_after_cnt: got %0d want 4", o_stall_cnt); end
  endtask

  task automatic test_saturation();
    do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 20; i++) tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 20; i++) tick();
    n_cmp++; if (o_stall_cnt !== 4'd15 || o_flush_cnt !== 4'd15) begin n_fail++; $display("FAIL saturate: got %0d/%0d want 15/15", o_stall_cnt, o_flush_cnt); end
  endtask

  task automatic test_rst_mid_freeze();
    do_reset();
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
    tick();
    drive(1, 5, 1, 0, 0, 0, 0, 0, 1, 1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if ({o_freeze, o_stall_if, o_stall_id, o_flush_if, o_flush_id} !== 5'b0 || o_fwd_rs1 !== 2'd0 || o_stage_valid !== 3'b0 || o_stall_cnt !== 4'd0) begin
      n_fail++; $display("FAIL rst_mid_freeze: got ctrl=%b fwd=%0d sv=%b sc=%0d want all 0", {o_freeze, o_stall_if, o_stall_id, o_flush_if, o_flush_id}, o_fwd_rs1, o_stage_valid, o_stall_cnt); end
    idle();
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    n_cmp++; if (o_stall_id !== 1'b0 || o_flush_if !== 1'b0 || o_stage_valid !== 3'b0) begin n_fail++; $display("FAIL rst_residual: got stall=%b flush=%b sv=%b want 0 0 000", o_stall_id, o_flush_if, o_stage_valid); end
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
            $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 2) == 0,
            $urandom_range(0, 9) == 0, $urandom_range(0, 6) == 0);
      @(negedge clk);
      model_eval();
      n_cmp++;
      if (o_stall_if !== e_stall || o_stall_id !== e_stall || o_flush_if !== e_flush_if ||
          o_flush_id !== e_flush_id || o_freeze !== mem_busy ||
          int'(o_fwd_rs1) != e_fwd1 || int'(o_fwd_rs2) != e_fwd2 ||
          o_stage_valid !== {m_pipe[2].v, m_pipe[1].v, m_pipe[0].v} ||
          int'(o_stall_cnt) != m_stall || int'(o_flush_cnt) != m_flush) begin
        n_fail++;
        $display("FAIL random_c%0d: got st=%b fi=%b fd=%b f1=%0d f2=%0d sv=%b sc=%0d fc=%0d want st=%b fi=%b fd=%b f1=%0d f2=%0d sv=%b%b%b sc=%0d fc=%0d",
                 c, o_stall_id, o_flush_if, o_flush_id, o_fwd_rs1, o_fwd_rs2, o_stage_valid, o_stall_cnt, o_flush_cnt,
                 e_stall, e_flush_if, e_flush_id, e_fwd1, e_fwd2, m_pipe[2].v, m_pipe[1].v, m_pipe[0].v, m_stall, m_flush);
      end
      tick();
    end
  endtask

  initial begin
    idle();
    model_reset();
    test_reset();
    test_forward_ex();
    test_load_use();
    test_youngest();
    test_redirect_over_loaduse();
    test_freeze();
    test_saturation();
    test_rst_mid_freeze();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter AW, default 5, register-index width (2^AW architectural registers, x0 hardwired zero).
REQ-002 SHALL have parameter DEPTH, default 3, number of tracked post-ID stages (index 0 = EX, DEPTH-1 = WB).
REQ-003 SHALL have parameter LOAD_STAGE, default 2, first stage index from which load data is forwardable; legal range 1..DEPTH-1.
REQ-004 SHALL have parameter CW, default 32, width of the performance counters.
REQ-005 clk  input  1  clock, rising-edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 id_valid  input  1  ID holds a real instruction.
REQ-008 id_rs1, id_rs2  input  AW each  ID source indices.
REQ-009 id_rs1_used, id_rs2_used  input  1 each  source actually read.
REQ-010 id_rd  input  AW  ID destination index.
REQ-011 id_reg_write, id_mem_read  input  1 each  ID writes rd / is a load.
REQ-012 ex_redirect  input  1  EX branch taken, jump or jalr.
REQ-013 mem_busy  input  1  data memory not ready; whole pipeline freezes.
REQ-014 stall_if, stall_id  output  1 each  hold PC and IF/ID register.
REQ-015 freeze  output  1  hold every pipeline register (equals mem_busy).
REQ-016 flush_if, flush_id  output  1 each  kill IF/ID content / insert bubble into ID/EX.
REQ-017 fwd_rs1, fwd_rs2  output  clog2(DEPTH+1) each  0 = register file, k+1 = result of stage k.
REQ-018 stage_valid  output  DEPTH  valid bit per tracked stage.
REQ-019 stall_cnt, flush_cnt  output  CW each  performance counters.

Function
REQ-020 SHALL keep a DEPTH-entry shift register of {valid, rd, reg_write, mem_read}; entry 0 = EX.
REQ-021 Match for stage k: valid & reg_write & rd==rs & rs!=0 & rs_used.
REQ-022 fwd_rsX SHALL select the lowest-index (youngest) matching stage, else 0.
REQ-023 Load-use: youngest match has mem_read=1 and index < LOAD_STAGE -> load_use=1.
REQ-024 When not frozen and no redirect: load_use -> stall_if=stall_id=1, flush_id=1, entry 0 loads a bubble.
REQ-025 ex_redirect (not frozen) -> flush_if=flush_id=1, stall_if=stall_id=0, entry 0 loads a bubble; redirect overrides load_use.
REQ-026 Normal advance: entry 0 <= {id_valid, id_rd, id_reg_write, id_mem_read}; entry k <= entry k-1; oldest entry discarded.
REQ-027 mem_busy=1: all entries hold; stall_if=stall_id=1; flush_if=flush_id=0; redirect and load_use acted on in first cycle mem_busy=0.
REQ-028 fwd_rsX SHALL be valid in every cycle including freeze, combinational from current entries and ID inputs.
REQ-029 stall_cnt SHALL increment once per cycle with stall_id=1; flush_cnt once per cycle with flush_if=1; both saturate at 2^CW-1.
REQ-030 id_valid=0 SHALL produce no stall and enter entry 0 as invalid.

Reset
REQ-031 rst=1 SHALL asynchronously clear all entries, stall_cnt, flush_cnt; hence stall_*, flush_*, fwd_* = 0 and stage_valid = 0.
REQ-032 Reset mid-stall or mid-freeze SHALL take effect immediately with no residual bubble or redirect.

Verification
REQ-033 Entry0 = add x5, ID reads rs1=x5 -> fwd_rs1=1, no stall.
REQ-034 Entry0 = lw x6, ID reads rs2=x6 -> stall_id=1, flush_id=1 one cycle; next cycle fwd_rs2=2 (LOAD_STAGE=2 -> 1-cycle stall if stage1<2? -> stall again), then fwd_rs2=3; stall_cnt=2.
REQ-035 Entry0 and entry1 both write x7, ID reads x7 -> fwd=1 (youngest); rd=x0 -> fwd=0.
REQ-036 ex_redirect with load_use same cycle -> flush_if=flush_id=1, stall_id=0, flush_cnt+1.
REQ-037 mem_busy 3 cycles with load_use pending -> entries unchanged, no flush, stall_cnt +0 from flush logic but +3 stall cycles; on release load_use stall resumes.
REQ-038 Counter at 2^CW-1 with further stall -> stays at max; rst mid-freeze -> all outputs 0 next sample.
